// File: rtl/pwm_shadow_load_8carr_pkg.sv
// pwm_shadow_load_8carr_pkg
//   Shared widths and encodings for the PWM double-buffered register loader.
//   PWM_WIDTH / PWMCOUNT_WIDTH are the carrier count and counter width used
//   across the PWM core; the enums name the load modes, write fields and the
//   group-commit FSM states.
package pwm_shadow_load_8carr_pkg;

  localparam int PWM_WIDTH      = 8;
  localparam int PWMCOUNT_WIDTH = 16;

  // Per-carrier load mode. LOAD_RSV behaves exactly like LOAD_EVT.
  typedef enum logic [1:0] {
    LOAD_IMM = 2'd0,
    LOAD_EVT = 2'd1,
    LOAD_GRP = 2'd2,
    LOAD_RSV = 2'd3
  } load_mode_e;

  typedef enum logic {
    FIELD_CMP = 1'b0,
    FIELD_PER = 1'b1
  } wr_field_e;

  typedef enum logic [1:0] {
    CS_IDLE  = 2'd0,
    CS_ARMED = 2'd1,
    CS_DONE  = 2'd2
  } commit_state_e;

endpackage

// File: rtl/pwm_shadow_load_8carr_shadow_reg.sv
// shadow_reg_16bits_1carr
//   One carrier's shadow/active register pair.
//   Ports:
//     clk, reset          clock, asynchronous active-low reset
//     wr_en, field, data  shadow write (field: 0 = compare, 1 = period)
//     load                transfer the pre-write shadow into active
//     imm                 a write on this cycle also loads its own new value
//     period, compare     active values
//     pending             shadow holds data not yet loaded
//     clamp               sticky: a load saturated compare to period
module shadow_reg_16bits_1carr
  import pwm_shadow_load_8carr_pkg::*;
#(
  parameter int               CNT_W       = PWMCOUNT_WIDTH,
  parameter logic [CNT_W-1:0] RST_PERIOD  = 16'd1000,
  parameter logic [CNT_W-1:0] RST_COMPARE = 16'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             field,
  input  logic [CNT_W-1:0] data,
  input  logic             load,
  input  logic             imm,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] compare,
  output logic             pending,
  output logic             clamp
);

  logic [CNT_W-1:0] sh_per, sh_cmp;
  logic [CNT_W-1:0] nx_per, nx_cmp;
  logic [CNT_W-1:0] src_per, src_cmp;
  logic             use_new, do_load, sat;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    nx_per = sh_per;
    nx_cmp = sh_cmp;
    if (wr_en) begin
      if (field == FIELD_PER) nx_per = data;
      else                    nx_cmp = data;
    end
    // Immediate loads take the value being written; event/group loads take
    // the shadow as it stood before this cycle's write.
    use_new = wr_en & imm;
    src_per = use_new ? nx_per : sh_per;
    src_cmp = use_new ? nx_cmp : sh_cmp;
    do_load = use_new | load;
    sat     = src_cmp > src_per;
  end

  // NOTE: shadow copies are reset along with the active values because
  // software may trigger a load before ever writing the shadow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_per  <= RST_PERIOD;
      sh_cmp  <= RST_COMPARE;
      period  <= RST_PERIOD;
      compare <= RST_COMPARE;
      pending <= 1'b0;
      clamp   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; blocking would leak new state into later lines.
      sh_per <= nx_per;
      sh_cmp <= nx_cmp;
      if (do_load) begin
        period  <= src_per;
        compare <= sat ? src_per : src_cmp;
      end
      // A write alongside an event load leaves the fresh value pending.
      pending <= use_new ? 1'b0 : (wr_en | (pending & ~load));
      // Saturation on this edge wins over the clear-by-write.
      clamp   <= (clamp & ~wr_en) | (do_load & sat);
    end
  end

endmodule

// File: rtl/pwm_shadow_load_8carr.sv
// pwm_shadow_load_8carr
//   Double-buffered period/compare loader for the 8-carrier PWM core.
//   Ports:
//     clk, reset                  clock, asynchronous active-low reset
//     wr_valid/wr_ready           shadow write handshake
//     wr_carr, wr_field, wr_data  write target carrier, field, value
//     load_mode_c                 per-carrier load mode (load_mode_e)
//     maskevent_c                 per-carrier masked event pulses
//     commit_req, commit_mask     group commit request and carrier set
//     period_c, compare_c         active values to the PWM core
//     pending_c, clamp_c          per-carrier status
//     commit_busy, commit_done    group commit status
module pwm_shadow_load_8carr
  import pwm_shadow_load_8carr_pkg::*;
#(
  parameter int               N_CARR      = PWM_WIDTH,
  parameter int               CNT_W       = PWMCOUNT_WIDTH,
  parameter logic [CNT_W-1:0] RST_PERIOD  = 16'd1000,
  parameter logic [CNT_W-1:0] RST_COMPARE = 16'd0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [2:0]                   wr_carr,
  input  logic                         wr_field,
  input  logic [CNT_W-1:0]             wr_data,
  input  logic [N_CARR-1:0][1:0]       load_mode_c,
  input  logic [N_CARR-1:0]            maskevent_c,
  input  logic                         commit_req,
  input  logic [N_CARR-1:0]            commit_mask,
  output logic [N_CARR-1:0][CNT_W-1:0] period_c,
  output logic [N_CARR-1:0][CNT_W-1:0] compare_c,
  output logic [N_CARR-1:0]            pending_c,
  output logic                         commit_busy,
  output logic                         commit_done,
  output logic [N_CARR-1:0]            clamp_c
);

  commit_state_e     state;
  logic [N_CARR-1:0] commit_mask_q;
  logic [N_CARR-1:0] remaining;
  logic [N_CARR-1:0] in_group, rem_next;
  logic [N_CARR-1:0] wr_en, load, imm;
  logic              ready_q, done_q, wr_fire;

  assign commit_busy = (state != CS_IDLE);
  assign commit_done = done_q;
  // Only carriers held by an active commit stall; others keep writing.
  assign wr_ready    = ready_q & ~(commit_busy & commit_mask_q[wr_carr]);
  assign wr_fire     = wr_valid & wr_ready;

  always_comb begin
    in_group = (state == CS_ARMED) ? remaining : '0;
    rem_next = remaining & ~maskevent_c;
    wr_en    = '0;
    load     = '0;
    imm      = '0;
    for (int i = 0; i < N_CARR; i++) begin
      wr_en[i] = wr_fire && (int'(wr_carr) == i);
      imm[i]   = (load_mode_c[i] == LOAD_IMM);
      // A carrier still owed a group load ignores its own event mode; the
      // group load fires on the event regardless of pending.
      load[i]  = maskevent_c[i] &
                 (in_group[i] |
                  (((load_mode_c[i] == LOAD_EVT) || (load_mode_c[i] == LOAD_RSV)) &
                   pending_c[i]));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= CS_IDLE;
      commit_mask_q <= '0;
      remaining     <= '0;
      done_q        <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      case (state)
        CS_IDLE: begin
          if (commit_req) begin
            commit_mask_q <= commit_mask;
            remaining     <= commit_mask;
            state         <= CS_DONE;
            if (|commit_mask) state <= CS_ARMED;
          end
        end
        CS_ARMED: begin
          remaining <= rem_next;
          if (rem_next == '0) begin
            state  <= CS_DONE;
            done_q <= 1'b1;
          end
        end
        CS_DONE: begin
          // Entered with done_q set after the last load; an empty commit
          // enters with it clear and raises the pulse one cycle later.
          if (done_q) begin
            state  <= CS_IDLE;
            done_q <= 1'b0;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state <= CS_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N_CARR; g++) begin : g_carr
    shadow_reg_16bits_1carr #(
      .CNT_W       (CNT_W),
      .RST_PERIOD  (RST_PERIOD),
      .RST_COMPARE (RST_COMPARE)
    ) u_shadow (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en[g]),
      .field   (wr_field),
      .data    (wr_data),
      .load    (load[g]),
      .imm     (imm[g]),
      .period  (period_c[g]),
      .compare (compare_c[g]),
      .pending (pending_c[g]),
      .clamp   (clamp_c[g])
    );
  end

endmodule

// File: tb/tb_pwm_shadow_load_8carr.sv
// tb_pwm_shadow_load_8carr
//   Self-checking bench for pwm_shadow_load_8carr. Expected per-carrier
//   register state is queued as stimulus is driven and compared once the
//   DUT output should reflect it.
module tb_pwm_shadow_load_8carr;
  import pwm_shadow_load_8carr_pkg::*;

  localparam int N = 8;
  localparam int W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_valid;
  logic             wr_ready;
  logic [2:0]       wr_carr;
  logic             wr_field;
  logic [W-1:0]     wr_data;
  logic [N-1:0][1:0] load_mode_c;
  logic [N-1:0]     maskevent_c;
  logic             commit_req;
  logic [N-1:0]     commit_mask;
  logic [N-1:0][W-1:0] period_c;
  logic [N-1:0][W-1:0] compare_c;
  logic [N-1:0]     pending_c;
  logic             commit_busy;
  logic             commit_done;
  logic [N-1:0]     clamp_c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        tag;
    int           carr;
    logic [W-1:0] per;
    logic [W-1:0] cmp;
    logic         pend;
    logic         clamp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pwm_shadow_load_8carr dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_carr     (wr_carr),
    .wr_field    (wr_field),
    .wr_data     (wr_data),
    .load_mode_c (load_mode_c),
    .maskevent_c (maskevent_c),
    .commit_req  (commit_req),
    .commit_mask (commit_mask),
    .period_c    (period_c),
    .compare_c   (compare_c),
    .pending_c   (pending_c),
    .commit_busy (commit_busy),
    .commit_done (commit_done),
    .clamp_c     (clamp_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string tag, input int c, input logic [W-1:0] per,
                         input logic [W-1:0] cmp, input logic pend, input logic clamp);
    exp_t e;
    e.tag = tag; e.carr = c; e.per = per; e.cmp = cmp; e.pend = pend; e.clamp = clamp;
    sb.push_back(e);
  endtask

  task automatic sb_drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, "_per"},   period_c[e.carr],  e.per);
      check({e.tag, "_cmp"},   compare_c[e.carr], e.cmp);
      check({e.tag, "_pend"},  pending_c[e.carr], e.pend);
      check({e.tag, "_clamp"}, clamp_c[e.carr],   e.clamp);
    end
  endtask

  // Drive one write and hold it until accepted, with a bounded wait.
  task automatic write(input int c, input logic f, input logic [W-1:0] d);
    int n;
    n = 0;
    wr_valid = 1'b1;
    wr_carr  = c[2:0];
    wr_field = f;
    wr_data  = d;
    #1;
    while (!wr_ready && n < 16) begin
      step();
      n++;
    end
    if (!wr_ready) check("wr_timeout", wr_ready, 1);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_evt(input int c);
    maskevent_c    = '0;
    maskevent_c[c] = 1'b1;
    step();
    maskevent_c = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset       = 1'b0;
    wr_valid    = 1'b0;
    wr_carr     = '0;
    wr_field    = FIELD_CMP;
    wr_data     = '0;
    maskevent_c = '0;
    commit_req  = 1'b0;
    commit_mask = '0;
    for (int c = 0; c < N; c++) load_mode_c[c] = LOAD_EVT;
    load_mode_c[0] = LOAD_IMM;
    load_mode_c[3] = LOAD_IMM;
    load_mode_c[7] = LOAD_GRP;

    // Reset state
    step(3);
    check("ready_in_reset", wr_ready, 0);
    check("busy_rst", commit_busy, 0);
    check("done_rst", commit_done, 0);
    for (int c = 0; c < N; c++) sb_push("rst", c, 16'd1000, 16'd0, 1'b0, 1'b0);
    sb_drain();
    reset = 1'b1;
    #1;
    check("ready_before_edge", wr_ready, 0);
    step();
    check("ready_after_edge", wr_ready, 1);

    // Event-mode load on carrier 2
    sb_push("evt_pre", 2, 16'd1000, 16'd0, 1'b1, 1'b0);
    write(2, FIELD_CMP, 16'd400);
    write(2, FIELD_PER, 16'd800);
    sb_drain();
    sb_push("evt_load", 2, 16'd800, 16'd400, 1'b0, 1'b0);
    pulse_evt(2);
    sb_drain();

    // Immediate mode and compare saturation on carrier 0
    sb_push("sat_per", 0, 16'd300, 16'd0, 1'b0, 1'b0);
    write(0, FIELD_PER, 16'd300);
    sb_drain();
    sb_push("sat_cmp", 0, 16'd300, 16'd300, 1'b0, 1'b1);
    write(0, FIELD_CMP, 16'd500);
    sb_drain();
    sb_push("sat_clr", 0, 16'd300, 16'd100, 1'b0, 1'b0);
    write(0, FIELD_CMP, 16'd100);
    sb_drain();

    // Write coincident with event on carrier 5
    sb_push("coin_pre", 5, 16'd1000, 16'd0, 1'b1, 1'b0);
    write(5, FIELD_CMP, 16'd100);
    sb_drain();
    wr_valid       = 1'b1;
    wr_carr        = 3'd5;
    wr_field       = FIELD_CMP;
    wr_data        = 16'd200;
    maskevent_c[5] = 1'b1;
    #1;
    check("coin_ready", wr_ready, 1);
    sb_push("coin_evt", 5, 16'd1000, 16'd100, 1'b1, 1'b0);
    step();
    wr_valid    = 1'b0;
    maskevent_c = '0;
    sb_drain();
    sb_push("coin_next", 5, 16'd1000, 16'd200, 1'b0, 1'b0);
    pulse_evt(5);
    sb_drain();

    // Group commit of carriers 0 and 7
    load_mode_c[0] = LOAD_GRP;
    write(0, FIELD_CMP, 16'd50);
    write(0, FIELD_PER, 16'd600);
    write(7, FIELD_PER, 16'd2000);
    write(7, FIELD_CMP, 16'd1500);
    sb_push("grp_hold0", 0, 16'd300, 16'd100, 1'b1, 1'b0);
    sb_push("grp_pre7", 7, 16'd1000, 16'd0, 1'b1, 1'b0);
    pulse_evt(0);
    sb_drain();
    commit_req  = 1'b1;
    commit_mask = 8'h81;
    step();                                   // now cycle t+1
    commit_req  = 1'b0;
    commit_mask = '0;
    check("grp_busy_t1", commit_busy, 1);
    check("grp_done_t1", commit_done, 0);
    wr_valid = 1'b1;
    wr_field = FIELD_CMP;
    wr_data  = 16'd9;
    wr_carr  = 3'd0;
    #1;
    check("grp_stall0", wr_ready, 0);
    wr_carr = 3'd7;
    #1;
    check("grp_stall7", wr_ready, 0);
    wr_carr = 3'd3;
    wr_data = 16'd77;
    #1;
    check("grp_ok3", wr_ready, 1);
    sb_push("grp_c3", 3, 16'd1000, 16'd77, 1'b0, 1'b0);
    sb_push("grp_c0_stalled", 0, 16'd300, 16'd100, 1'b1, 1'b0);
    @(posedge clk);
    #1;                                       // cycle t+2
    wr_valid = 1'b0;
    sb_drain();
    step(3);                                  // cycle t+5
    maskevent_c[0] = 1'b1;
    sb_push("grp_c0", 0, 16'd600, 16'd50, 1'b0, 1'b0);
    step();                                   // cycle t+6
    maskevent_c = '0;
    sb_drain();
    check("grp_busy_t6", commit_busy, 1);
    step(6);                                  // cycle t+12
    check("grp_done_t12", commit_done, 0);
    maskevent_c[7] = 1'b1;
    sb_push("grp_c7", 7, 16'd2000, 16'd1500, 1'b0, 1'b0);
    step();                                   // cycle t+13
    maskevent_c = '0;
    check("grp_done_t13", commit_done, 1);
    sb_drain();
    step();
    check("grp_done_t14", commit_done, 0);
    check("grp_busy_t14", commit_busy, 0);
    wr_carr = 3'd0;
    #1;
    check("grp_ready0_after", wr_ready, 1);

    // Zero-mask commit
    commit_req  = 1'b1;
    commit_mask = '0;
    step();
    commit_req = 1'b0;
    check("zero_busy_1", commit_busy, 1);
    check("zero_done_1", commit_done, 0);
    step();
    check("zero_done_2", commit_done, 1);
    step();
    check("zero_done_3", commit_done, 0);
    check("zero_busy_3", commit_busy, 0);

    // Reset asserted while ARMED
    write(2, FIELD_CMP, 16'd10);
    commit_req  = 1'b1;
    commit_mask = 8'h04;
    step();
    commit_req  = 1'b0;
    commit_mask = '0;
    check("mid_busy", commit_busy, 1);
    reset = 1'b0;
    #1;
    check("mid_busy_rst", commit_busy, 0);
    check("mid_ready_rst", wr_ready, 0);
    check("mid_done_rst", commit_done, 0);
    for (int c = 0; c < N; c++) sb_push("mid_rst", c, 16'd1000, 16'd0, 1'b0, 1'b0);
    sb_drain();
    for (int k = 0; k < 3; k++) begin
      maskevent_c[2] = 1'b1;
      step();
      check("mid_no_done", commit_done, 0);
    end
    maskevent_c = '0;
    reset = 1'b1;
    step();
    check("post_rst_done", commit_done, 0);
    check("post_rst_busy", commit_busy, 0);
    check("post_rst_ready", wr_ready, 1);
    sb_push("post_rst", 2, 16'd1000, 16'd0, 1'b0, 1'b0);
    sb_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
